// File: rtl/imem_responder.sv
// Instruction-memory responder: slave end of the fetch req/addr/ack/data interface.
// A word RAM mapped at BASE_ADDR answers held fetch requests after LATENCY wait cycles.
module imem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ack,
  output logic [31:0] data,
  output logic        err,
  input  logic        ld_wen,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  // Handshake: req stays high with a stable addr until ack; ack is a one-cycle
  // registered pulse carrying data/err. Dropping req before ack abandons the fetch,
  // and a changed addr while waiting restarts the wait for the new address.

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]      cur_off, ld_off;
  logic             cur_valid, ld_valid;
  logic [IDX_W-1:0] cur_idx, ld_idx;
  logic [31:0]      rd_word;

  assign cur_off   = cur_addr_q - BASE_ADDR;
  assign cur_valid = (cur_addr_q[1:0] == 2'b00) && ({1'b0, cur_off} < SPAN);
  assign cur_idx   = cur_off[IDX_W+1:2];

  assign ld_off    = ld_addr - BASE_ADDR;
  assign ld_valid  = (ld_addr[1:0] == 2'b00) && ({1'b0, ld_off} < SPAN);
  assign ld_idx    = ld_off[IDX_W+1:2];

  // Write-first: a load to the word being fetched on the same edge wins.
  assign rd_word = (ld_wen && ld_valid && (ld_idx == cur_idx)) ? ld_data : mem[cur_idx];

  // The load port ignores reset so a program can be preloaded while held in reset.
  always_ff @(posedge clk) begin
    if (ld_wen && ld_valid) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    cnt_d         = cnt_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    data_d        = data_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cur_addr_d = addr;
          cnt_d      = LAT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (addr != cur_addr_q) begin
          cur_addr_d = addr;
          cnt_d      = LAT;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = S_ACK;
          if (cur_valid) begin
            data_d = rd_word;
          end else begin
            data_d = 32'd0;
            err_d  = 1'b1;
          end
        end
      end
      S_ACK: begin
        // req is ignored here: the requester moves addr on the edge consuming ack.
        fetch_count_d = fetch_count_q + 32'd1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= 32'd0;
      cnt_q         <= 4'd0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      data_q        <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      data_q        <= data_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign data        = data_q;
  assign fetch_count = fetch_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, sequential fetch, redirect, errors,
// write-first bypass, dropped loads, abandonment and reset during ACK.
module tb_imem_responder;

  localparam int          MEM_WORDS = 4096;
  localparam int          LATENCY   = 2;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  localparam logic [31:0] W0   = 32'h0050_0093;
  localparam logic [31:0] W1   = 32'h00A0_0113;
  localparam logic [31:0] W2   = 32'h00F0_0193;
  localparam logic [31:0] W4   = 32'h1234_5678;
  localparam logic [31:0] W64  = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        err;
  logic        ld_wen;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  imem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE),
    .LATENCY  (LATENCY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .addr       (addr),
    .ack        (ack),
    .data       (data),
    .err        (err),
    .ld_wen     (ld_wen),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .fetch_count(fetch_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    ld_wen  = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_wen  = 1'b0;
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (ack === 1'b1) break;
      if (n > max) break;
    end
  endtask

  task automatic fetch_one(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_d, input logic exp_e);
    int n;
    req  = 1'b1;
    addr = a;
    wait_ack(40, n);
    check_eq({tag, "_ack"}, 32'(ack), 32'd1);
    check_eq({tag, "_lat"}, 32'(n), 32'(LATENCY + 2));
    check_eq({tag, "_data"}, data, exp_d);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_e));
    req = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int acks;
    int last;
    int extra;

    reset_n = 1'b0;
    req     = 1'b0;
    addr    = 32'd0;
    ld_wen  = 1'b0;
    ld_addr = 32'd0;
    ld_data = 32'd0;
    tick();
    tick();
    // Preload while still in reset.
    load_word(BASE,          W0);
    load_word(BASE + 32'h4,  W1);
    load_word(BASE + 32'h8,  W2);
    load_word(BASE + 32'h10, W4);
    load_word(BASE + 32'h100, W64);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_data", data, 32'd0);
    check_eq("rst_cnt", fetch_count, 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single fetch: ack in the cycle after edge LATENCY+1.
    fetch_one("first", BASE, W0, 1'b0);
    check_eq("first_ack_low", 32'(ack), 32'd0);
    check_eq("first_cnt", fetch_count, 32'd1);
    check_eq("first_state", 32'(state_dbg), 32'd0);

    // Sequential fetch with addr advancing on each ack.
    exp_q.push_back(W0);
    exp_q.push_back(W1);
    exp_q.push_back(W2);
    req  = 1'b1;
    addr = BASE;
    acks = 0;
    last = 0;
    for (int c = 0; c < 60 && acks < 3; c++) begin
      tick();
      if (ack === 1'b1) begin
        check_eq("seq_data", data, exp_q.pop_front());
        check_eq("seq_err", 32'(err), 32'd0);
        if (acks > 0) check_eq("seq_gap", 32'(c - last), 32'(LATENCY + 3));
        last = c;
        acks++;
        addr = addr + 32'd4;
        if (acks == 3) req = 1'b0;
      end
    end
    check_eq("seq_acks", 32'(acks), 32'd3);
    tick();
    check_eq("seq_cnt", fetch_count, 32'd4);

    // Redirect one cycle after capture.
    req  = 1'b1;
    addr = BASE;
    tick();
    check_eq("redir_wait", 32'(state_dbg), 32'd1);
    addr = BASE + 32'h100;
    wait_ack(40, n);
    check_eq("redir_ack", 32'(ack), 32'd1);
    check_eq("redir_lat", 32'(n), 32'(LATENCY + 2));
    check_eq("redir_data", data, W64);
    req = 1'b0;
    tick();
    check_eq("redir_hold", data, W64);
    check_eq("redir_cnt", fetch_count, 32'd5);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack === 1'b1) extra++;
    end
    check_eq("redir_extra", 32'(extra), 32'd0);

    // Error responses.
    fetch_one("mis", BASE + 32'h2, 32'd0, 1'b1);
    fetch_one("below", 32'h7FFF_FFFC, 32'd0, 1'b1);
    fetch_one("above", BASE + 32'(4 * MEM_WORDS), 32'd0, 1'b1);
    check_eq("err_cnt", fetch_count, 32'd8);

    // Write-first bypass on the read edge (edge LATENCY+1).
    req  = 1'b1;
    addr = BASE + 32'h10;
    repeat (LATENCY + 1) tick();
    check_eq("byp_pre", 32'(ack), 32'd0);
    ld_wen  = 1'b1;
    ld_addr = BASE + 32'h10;
    ld_data = 32'hDEAD_BEEF;
    tick();
    ld_wen = 1'b0;
    check_eq("byp_ack", 32'(ack), 32'd1);
    check_eq("byp_data", data, 32'hDEAD_BEEF);
    req = 1'b0;
    tick();
    fetch_one("byp_rb", BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Out-of-range and misaligned loads would alias onto word 0 if not dropped.
    load_word(BASE + 32'(4 * MEM_WORDS), 32'hBADB_AD00);
    load_word(BASE + 32'h2, 32'hBADB_AD01);
    fetch_one("drop", BASE, W0, 1'b0);
    check_eq("drop_cnt", fetch_count, 32'd11);

    // Abandon in WAIT.
    req  = 1'b1;
    addr = BASE + 32'h4;
    tick();
    tick();
    check_eq("ab_wait", 32'(state_dbg), 32'd1);
    req = 1'b0;
    tick();
    check_eq("ab_idle", 32'(state_dbg), 32'd0);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack === 1'b1) extra++;
    end
    check_eq("ab_noack", 32'(extra), 32'd0);
    check_eq("ab_cnt", fetch_count, 32'd11);

    // Reset asserted during ACK.
    req  = 1'b1;
    addr = BASE + 32'h8;
    wait_ack(40, n);
    check_eq("ra_ack", 32'(ack), 32'd1);
    reset_n = 1'b0;
    req     = 1'b0;
    tick();
    check_eq("ra_ack_low", 32'(ack), 32'd0);
    check_eq("ra_cnt", fetch_count, 32'd0);
    check_eq("ra_data", data, 32'd0);
    check_eq("ra_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    tick();
    fetch_one("post_rst", BASE + 32'h8, W2, 1'b0);
    check_eq("post_cnt", fetch_count, 32'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
